big_divider: RTL and testbench



---
 rtl/fp_alu_pkg.sv | 20 ++
 rtl/big_divider_div_step.sv | 33 +++
 rtl/big_divider.sv | 124 ++++++++++++
 tb/tb_big_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_alu_pkg : constants and types shared by the FP datapath (BigALU, divider)
// Revision   : 1.0
// ----------------------------------------------------------------------------
package fp_alu_pkg;

  localparam int FP_MANT_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Wide enough for any practical mantissa; users take the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage : fp_alu_pkg
`default_nettype wire

// File: rtl/big_divider_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_step : one combinational restoring shift-subtract iteration on {R,Q}
// Revision : 1.0
// ----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] trial;

  // shifted_rem < 2*divisor, so a WIDTH+1 bit difference keeps a valid sign bit.
  assign shifted_rem = {rem_in, quo_in[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, divisor};

  always_comb begin
    rem_out = shifted_rem[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/big_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// big_divider : sequential unsigned restoring divider, one quotient bit/clock
// Revision    : 1.0
// ----------------------------------------------------------------------------
module big_divider
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = FP_MANT_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] dvs_q,       dvs_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = DIV0_QUOTIENT[WIDTH-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dividend;
          end
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        // Final iteration publishes the result on the same edge.
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_DONE;
          quotient_d  = step_quo;
          remainder_d = step_rem;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == ST_CALC);
  assign done        = (state_q == ST_DONE);

endmodule : big_divider
`default_nettype wire

// File: tb/tb_big_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_big_divider : vector table, corner sequences and random checks vs a model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_big_divider;

  localparam int W = 23;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  big_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = ALL1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Launch one division from a negedge; optionally poke start=1 (9/3) at cycle poke_at.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at,
                         output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0; busy_n = 0;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (lat == poke_at) begin
        start = 1'b1; dividend = 23'd9; divisor = 23'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) chk("done_timeout", lat, -1);
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int poke_at);
    int lat, busy_n;
    run_div(a, b, poke_at, lat, busy_n);
    chk({tag, "_latency"}, lat, ez ? 0 : W);
    chk({tag, "_busy_cycles"}, busy_n, ez ? 0 : W);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_by_zero"}, div_by_zero, ez);
    @(negedge clk);
    chk({tag, "_done_single"}, done, 0);
    chk({tag, "_hold_q"}, quotient, eq);
  endtask

  vec_t vecs[9];

  initial begin
    int lat, busy_n, done_seen;
    logic [W-1:0] ra, rb, mq, mr;
    logic mz;

    vecs[0] = '{23'd100,      23'd7,        23'd14,      23'd2, 1'b0};
    vecs[1] = '{23'd20,       23'd5,        23'd4,       23'd0, 1'b0};
    vecs[2] = '{23'd5,        23'd20,       23'd0,       23'd5, 1'b0};
    vecs[3] = '{23'd20,       23'd0,        23'h7FFFFF,  23'd20, 1'b1};
    vecs[4] = '{23'd40,       23'd1,        23'd40,      23'd0, 1'b0};
    vecs[5] = '{23'h7FFFFF,   23'd1,        23'h7FFFFF,  23'd0, 1'b0};
    vecs[6] = '{23'h7FFFFF,   23'h7FFFFF,   23'd1,       23'd0, 1'b0};
    vecs[7] = '{23'h400000,   23'd3,        23'd1398101, 23'd1, 1'b0};
    vecs[8] = '{23'd0,        23'd0,        23'h7FFFFF,  23'd0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1);

    // start during CALC is ignored, single done pulse
    check_op("ignore_start", 23'd100, 23'd7, 23'd14, 23'd2, 1'b0, 10);

    // start held high: new op begins one cycle after done
    @(negedge clk);
    start = 1'b1; dividend = 23'd20; divisor = 23'd5;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_done", done, 1);
    chk("b2b_first_q", quotient, 4);
    @(negedge clk);
    chk("b2b_idle_gap_busy", busy, 0);
    chk("b2b_idle_gap_done", done, 0);
    @(negedge clk);
    chk("b2b_restart_busy", busy, 1);
    dividend = 23'd77; divisor = 23'd9;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_q", quotient, 4);
    chk("b2b_second_r", remainder, 0);
    @(negedge clk);

    // Reset mid-operation abandons the divide
    start = 1'b1; dividend = 23'd100; divisor = 23'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("midrst_no_activity", done_seen, 0);
    check_op("post_rst", 23'd20, 23'd5, 23'd4, 23'd0, 1'b0, -1);

    // Randomised operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, W);
      if (i % 10 == 3) rb = '0;
      model(ra, rb, mq, mr, mz);
      check_op($sformatf("rnd%0d", i), ra, rb, mq, mr, mz, (i % 4 == 0) ? 5 : -1);
      if (!mz) begin
        chk($sformatf("rnd%0d_invariant", i),
            longint'(quotient) * longint'(rb) + longint'(remainder), longint'(ra));
        chk($sformatf("rnd%0d_rem_lt_div", i), (remainder < rb) ? 1 : 0, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule : tb_big_divider
`default_nettype wire
